// File: rtl/spw_tx_clkdiv_ctrl_pkg.sv
// spw_tx_clkdiv_ctrl_pkg: register map and bit positions for the SpaceWire TX divisor block
package spw_tx_clkdiv_ctrl_pkg;
    typedef enum logic [1:0] {
        REG_DIV    = 2'd0,
        REG_CTRL   = 2'd1,
        REG_STATUS = 2'd2,
        REG_COUNT  = 2'd3
    } reg_addr_e;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_FORCE   = 2;
    localparam int STAT_PEND    = 0;
    localparam int STAT_EN      = 1;
    localparam int STAT_CNT_LSB = 8;
endpackage

// File: rtl/spw_tx_clkdiv_ctrl_if.sv
// spw_tx_clkdiv_ctrl_if: Avalon-MM register port of the TX divisor block
interface spw_tx_clkdiv_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport slave(input address, chipselect, write_n, writedata, output readdata);
    modport master(output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/spw_tx_clkdiv_ctrl_counter.sv
// spw_tx_clkdiv_ctrl_counter: reloading down-counter producing the TX bit-rate tick
module spw_tx_clkdiv_ctrl_counter #(
    parameter int DIV_W     = 7,
    parameter int RESET_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic [DIV_W-1:0] div,
    output logic [DIV_W-1:0] cnt,
    output logic             tick_en
);
    // count down while enabled, wrap to the active divisor, explicit loads win
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= DIV_W'(RESET_DIV);
        else if (load) cnt <= load_val;
        else if (en) cnt <= (cnt == '0) ? div : cnt - 1'b1;
    end
    assign tick_en = reset_n & en & (cnt == '0);
endmodule

// File: rtl/spw_tx_clkdiv_ctrl.sv
// spw_tx_clkdiv_ctrl: Avalon divisor register with shadow and glitch-free apply for the SpaceWire TX clock
module spw_tx_clkdiv_ctrl
    import spw_tx_clkdiv_ctrl_pkg::*;
#(
    parameter int DIV_W     = 7,
    parameter int RESET_DIV = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spw_tx_clkdiv_ctrl_if.slave  bus,
    output logic [DIV_W-1:0]     out_port,
    output logic                 tick_en,
    output logic                 update_pending
);
    logic [DIV_W-1:0] shadow, div_active, cnt;
    logic [CNT_W-1:0] apply_cnt;
    logic             en, auto_en, pending;
    logic             wr, wr_div, wr_ctrl, en_rise;
    logic             force_apply, auto_apply, idle_apply, apply;
    logic [31:0]      status;
    logic             unused_wd;

    assign wr          = bus.chipselect & ~bus.write_n;
    assign wr_div      = wr & (bus.address == REG_DIV);
    assign wr_ctrl     = wr & (bus.address == REG_CTRL);
    assign en_rise     = wr_ctrl & bus.writedata[CTRL_EN] & ~en;
    assign force_apply = wr_ctrl & bus.writedata[CTRL_FORCE] & pending;
    assign auto_apply  = pending & en & auto_en & (cnt == '0);
    assign idle_apply  = pending & ~en;
    assign apply       = force_apply | auto_apply | idle_apply;

    // a forced apply restarts the period, so the counter sits out that cycle and no tick fires
    spw_tx_clkdiv_ctrl_counter #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en & ~force_apply),
        .load     (apply | en_rise),
        .load_val (apply ? shadow : div_active),
        .div      (div_active),
        .cnt      (cnt),
        .tick_en  (tick_en)
    );

    // register file: shadow, control bits, pending flag and the apply hand-over into div_active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow     <= DIV_W'(RESET_DIV);
            div_active <= DIV_W'(RESET_DIV);
            en         <= 1'b1;
            auto_en    <= 1'b1;
            pending    <= 1'b0;
            apply_cnt  <= '0;
        end else begin
            if (wr_div) shadow <= bus.writedata[DIV_W-1:0];
            if (wr_ctrl) begin
                en      <= bus.writedata[CTRL_EN];
                auto_en <= bus.writedata[CTRL_AUTO];
            end
            if (apply) begin
                div_active <= shadow;
                apply_cnt  <= apply_cnt + CNT_W'(1);
            end
            pending <= wr_div | (pending & ~apply);
        end
    end

    assign status = (32'(apply_cnt) << STAT_CNT_LSB) | (32'(en) << STAT_EN) | (32'(pending) << STAT_PEND);
    assign bus.readdata = (bus.address == REG_DIV)    ? 32'(shadow) :
                          (bus.address == REG_CTRL)   ? 32'({auto_en, en}) :
                          (bus.address == REG_STATUS) ? status : 32'(cnt);
    assign out_port       = div_active;
    assign update_pending = pending;
    assign unused_wd      = ^bus.writedata;
endmodule
